fp16_normalize: RTL

Post-add normalize/round/pack stage of the half-precision adder. It sits after the mantissa adder, at the opposite end of the datapath from operand alignment. It takes the raw 12-bit magnitude sum, the common exponent, and the guard/sticky bits. It normalizes with a one-bit-per-cycle iterative shifter, rounds to nearest-even, and emits a packed IEEE fp16 result under a valid/ready handshake.

---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_round_rne.sv | 21 ++
 rtl/fp16_normalize.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 adder post-add stages.
package fp16_pkg;

  localparam int unsigned FP16_BIAS    = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
  localparam int unsigned FP16_MANT_W  = 10;
  localparam logic [4:0]  FP16_INF_EXP = FP16_EXP_MAX;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_e;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even increment of an 11-bit {hidden, frac} mantissa.
module fp16_round_rne
  import fp16_pkg::*;
(
  input  logic [FP16_MANT_W:0] mant_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  output logic [FP16_MANT_W:0] mant_o,
  output logic                 carry_o
);

  logic                   inc;
  logic [FP16_MANT_W+1:0] sum;

  assign inc     = guard_i & (sticky_i | mant_i[0]);
  assign sum     = {1'b0, mant_i} + {{(FP16_MANT_W + 1){1'b0}}, inc};
  assign carry_o = sum[FP16_MANT_W+1];
  // A wrap to 2048 becomes 1.0 (1024); the caller bumps the exponent.
  assign mant_o  = carry_o ? {1'b1, {FP16_MANT_W{1'b0}}} : sum[FP16_MANT_W:0];

endmodule

// File: rtl/fp16_normalize.sv
// Post-add normalize / round / pack stage: iterative 1-bit shifter, RNE rounding, fp16 pack.
module fp16_normalize
  import fp16_pkg::*;
#(
  parameter int unsigned MANT_W = 10,
  parameter int unsigned EXP_W  = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    OUT_READY,
  input  logic                    IN_SIGN_HALF,
  input  logic [EXP_W-1:0]        IN_EXP_HALF,
  input  logic [MANT_W+1:0]       IN_MANT_SUM_HALF,
  input  logic                    IN_GUARD_BIT,
  input  logic                    IN_STICKY_BIT,
  input  logic                    IN_EXCEPTION_HALF,
  output logic                    OUT_VALID,
  input  logic                    IN_READY,
  output logic [EXP_W+MANT_W:0]   OUT_RESULT_HALF,
  output logic                    OUT_OVERFLOW_HALF,
  output logic                    OUT_UNDERFLOW_HALF,
  output logic                    OUT_INEXACT_HALF,
  output logic                    OUT_EXCEPTION_HALF
);

  localparam int unsigned SumW   = MANT_W + 2;
  localparam int unsigned ResW   = EXP_W + MANT_W + 1;
  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [SumW-1:0]     mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic [ResW-1:0]     result_q, result_d;
  logic                ovf_q, ovf_d, uf_q, uf_d, inex_q, inex_d, exc_q, exc_d;

  logic [MANT_W:0]     rnd_mant;
  logic                rnd_carry;
  logic [EXP_W-1:0]    exp_inc, exp_rnd, exp_field;
  logic                rnd_inexact;

  fp16_round_rne u_round (
    .mant_i   (mant_q[MANT_W:0]),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry)
  );

  assign exp_inc     = exp_q + ExpOne;
  assign exp_rnd     = rnd_carry ? exp_inc : exp_q;
  // Only a mantissa with the hidden bit set carries a nonzero exponent field.
  assign exp_field   = rnd_mant[MANT_W] ? exp_rnd : '0;
  assign rnd_inexact = guard_q | sticky_q;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    uf_d     = uf_q;
    inex_d   = inex_q;
    exc_d    = exc_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          sign_d   = IN_SIGN_HALF;
          exp_d    = (IN_EXP_HALF == '0) ? ExpOne : IN_EXP_HALF;
          mant_d   = IN_MANT_SUM_HALF;
          guard_d  = IN_GUARD_BIT;
          sticky_d = IN_STICKY_BIT;
          ovf_d    = 1'b0;
          uf_d     = 1'b0;
          inex_d   = 1'b0;
          exc_d    = 1'b0;
          if (IN_EXCEPTION_HALF) begin
            result_d = {IN_SIGN_HALF, FP16_INF_EXP, {MANT_W{1'b0}}};
            exc_d    = 1'b1;
            state_d  = StDone;
          end else if ((IN_MANT_SUM_HALF == '0) && !IN_GUARD_BIT && !IN_STICKY_BIT) begin
            result_d = {IN_SIGN_HALF, {(EXP_W + MANT_W){1'b0}}};
            state_d  = StDone;
          end else begin
            state_d  = StNorm;
          end
        end
      end
      StNorm: begin
        if (mant_q[SumW-1]) begin
          // Carry out of the adder: shift right, then re-examine next cycle.
          mant_d   = {1'b0, mant_q[SumW-1:1]};
          guard_d  = mant_q[0];
          sticky_d = sticky_q | guard_q;
          exp_d    = exp_inc;
          if (exp_inc == FP16_EXP_MAX) begin
            result_d = {sign_q, FP16_INF_EXP, {MANT_W{1'b0}}};
            ovf_d    = 1'b1;
            inex_d   = 1'b1;
            state_d  = StDone;
          end
        end else if (!mant_q[MANT_W] && (exp_q > ExpOne)) begin
          mant_d  = {mant_q[SumW-2:0], guard_q};
          guard_d = 1'b0;
          exp_d   = exp_q - ExpOne;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        inex_d = rnd_inexact;
        if (rnd_carry && (exp_rnd == FP16_EXP_MAX)) begin
          result_d = {sign_q, FP16_INF_EXP, {MANT_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_field, rnd_mant[MANT_W-1:0]};
          uf_d     = (exp_field == '0) & rnd_inexact;
        end
        state_d = StDone;
      end
      StDone: begin
        if (IN_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      uf_q     <= 1'b0;
      inex_q   <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      uf_q     <= uf_d;
      inex_q   <= inex_d;
      exc_q    <= exc_d;
    end
  end

  assign OUT_READY          = (state_q == StIdle) & ~RST;
  assign OUT_VALID          = (state_q == StDone);
  assign OUT_RESULT_HALF    = result_q;
  assign OUT_OVERFLOW_HALF  = ovf_q;
  assign OUT_UNDERFLOW_HALF = uf_q;
  assign OUT_INEXACT_HALF   = inex_q;
  assign OUT_EXCEPTION_HALF = exc_q;

endmodule
